// File: rtl/mu0_mem_arb_pkg.sv
// Shared types and constants for the MU0 single-port RAM arbiter.
package mu0_mem_arb_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 2;

    localparam logic [ADDR_W-1:0] MEM_TOP_DEFAULT = 12'hEFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] top);
        return addr <= top;
    endfunction

endpackage

// File: rtl/mu0_rr_arbiter.sv
// Two-way round-robin picker; remembers the last requester granted.
module mu0_rr_arbiter
    import mu0_mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    c_req,
    input  logic    d_req,
    input  logic    grant_en,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t last_reg;

    always_comb begin
        grant_valid = c_req | d_req;
        if (c_req && d_req) begin
            grant_id = (last_reg == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (c_req) begin
            grant_id = REQ_CPU;
        end else begin
            grant_id = REQ_DBG;
        end
    end

    // Starting from DBG means the CPU wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= REQ_DBG;
        end else if (grant_en && grant_valid) begin
            last_reg <= grant_id;
        end
    end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Arbitrates CPU and debug/loader requesters onto one single-port RAM.
// Each access is IDLE -> ACCESS -> RESP (out-of-range skips ACCESS).
module mu0_mem_arbiter
    import mu0_mem_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_TOP = MEM_TOP_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              C_Req,
    input  logic              C_Wr,
    input  logic [ADDR_W-1:0] C_Addr,
    input  logic [DATA_W-1:0] C_Wdata,
    output logic              C_Ack,
    output logic              C_Err,
    output logic [DATA_W-1:0] C_Rdata,
    input  logic              D_Req,
    input  logic              D_Wr,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_Wdata,
    output logic              D_Ack,
    output logic              D_Err,
    output logic [DATA_W-1:0] D_Rdata,
    output logic              Mem_Wr,
    output logic              Mem_Rd,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic [DATA_W-1:0] Mem_Rdata,
    output logic              Busy
);

    state_t  state_reg, state_next;
    req_id_t owner_reg, owner_next;
    req_id_t grant_id;
    logic    grant_valid, grant_en;
    logic    wr_reg, wr_next;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;

    logic              mem_rd_reg, mem_rd_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              busy_reg;

    logic [NUM_REQ-1:0] ack_next, err_next, rdata_load;
    logic [NUM_REQ-1:0] ack_reg, err_reg;
    logic [DATA_W-1:0]  rdata_reg [NUM_REQ];

    assign grant_en = (state_reg == ST_IDLE);

    mu0_rr_arbiter u_rr (
        .clk         (Clk),
        .rst         (Reset),
        .c_req       (C_Req),
        .d_req       (D_Req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        if (grant_id == REQ_DBG) begin
            sel_wr    = D_Wr;
            sel_addr  = D_Addr;
            sel_wdata = D_Wdata;
        end else begin
            sel_wr    = C_Wr;
            sel_addr  = C_Addr;
            sel_wdata = C_Wdata;
        end
        sel_ok = addr_in_range(sel_addr, MEM_TOP);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = sel_ok ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        owner_next     = owner_reg;
        wr_next        = wr_reg;
        mem_rd_next    = 1'b0;
        mem_wr_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ack_next       = '0;
        err_next       = '0;
        rdata_load     = '0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_id;
                    wr_next    = sel_wr;
                    if (sel_ok) begin
                        mem_rd_next    = ~sel_wr;
                        mem_wr_next    = sel_wr;
                        mem_addr_next  = sel_addr;
                        mem_wdata_next = sel_wdata;
                    end else begin
                        err_next[grant_id] = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                ack_next[owner_reg]   = 1'b1;
                rdata_load[owner_reg] = ~wr_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= REQ_CPU;
            wr_reg        <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            wr_reg        <= wr_next;
            mem_rd_reg    <= mem_rd_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic              ack_r;
            logic              err_r;
            logic [DATA_W-1:0] rdata_r;

            // RAM data changes on the falling edge, so it is stable here.
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= '0;
                end else begin
                    ack_r <= ack_next[gi];
                    err_r <= err_next[gi];
                    if (rdata_load[gi]) begin
                        rdata_r <= Mem_Rdata;
                    end
                end
            end

            assign ack_reg[gi]   = ack_r;
            assign err_reg[gi]   = err_r;
            assign rdata_reg[gi] = rdata_r;
        end
    endgenerate

    assign C_Ack     = ack_reg[REQ_CPU];
    assign C_Err     = err_reg[REQ_CPU];
    assign C_Rdata   = rdata_reg[REQ_CPU];
    assign D_Ack     = ack_reg[REQ_DBG];
    assign D_Err     = err_reg[REQ_DBG];
    assign D_Rdata   = rdata_reg[REQ_DBG];
    assign Mem_Rd    = mem_rd_reg;
    assign Mem_Wr    = mem_wr_reg;
    assign Mem_Addr  = mem_addr_reg;
    assign Mem_Wdata = mem_wdata_reg;
    assign Busy      = busy_reg;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Scoreboard bench for mu0_mem_arbiter with a negedge-updated RAM model.
module tb_mu0_mem_arbiter;

    logic        Clk, Reset;
    logic        C_Req, C_Wr, D_Req, D_Wr;
    logic [11:0] C_Addr, D_Addr;
    logic [15:0] C_Wdata, D_Wdata;
    logic        C_Ack, C_Err, D_Ack, D_Err;
    logic [15:0] C_Rdata, D_Rdata;
    logic        Mem_Wr, Mem_Rd;
    logic [11:0] Mem_Addr;
    logic [15:0] Mem_Wdata, Mem_Rdata;
    logic        Busy;

    mu0_mem_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .C_Req(C_Req), .C_Wr(C_Wr), .C_Addr(C_Addr), .C_Wdata(C_Wdata),
        .C_Ack(C_Ack), .C_Err(C_Err), .C_Rdata(C_Rdata),
        .D_Req(D_Req), .D_Wr(D_Wr), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
        .D_Ack(D_Ack), .D_Err(D_Err), .D_Rdata(D_Rdata),
        .Mem_Wr(Mem_Wr), .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr),
        .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Busy(Busy)
    );

    typedef struct {
        logic        id;
        logic        wr;
        logic        err;
        logic [11:0] addr;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem       [4096];
    logic [15:0] model_mem [4096];
    logic [15:0] model_rdata [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_resp_cyc = -1;
    int   pulse_cnt = 0;
    logic [11:0] pulse_addr;
    logic pulse_wr;
    logic gap_chk = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Mem_Wr) mem[Mem_Addr] = Mem_Wdata;
        if (Mem_Rd) Mem_Rdata <= mem[Mem_Addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_txn(input logic id, input logic wr,
                                       input logic [11:0] addr, input logic [15:0] wdata);
        exp_t e;
        e.id   = id;
        e.wr   = wr;
        e.addr = addr;
        e.err  = (addr > 12'hEFF);
        if (!e.err && wr)  model_mem[addr] = wdata;
        if (!e.err && !wr) model_rdata[id] = model_mem[addr];
        e.rdata = model_rdata[id];
        exp_q.push_back(e);
    endfunction

    // Response monitor: pops one expectation per Ack/Err pulse.
    logic  rc, rdr, rid;
    exp_t  e_mon;
    always @(negedge Clk) begin
        if (Reset) begin
            pulse_cnt = 0;
        end else begin
            rc  = C_Ack | C_Err;
            rdr = D_Ack | D_Err;
            if (rc | rdr) begin
                check("one_resp", 32'(rc) + 32'(rdr), 32'd1);
                check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    rid   = rdr;
                    check("resp_id", 32'(rid), 32'(e_mon.id));
                    check("resp_err", 32'(rid ? D_Err : C_Err), 32'(e_mon.err));
                    check("ack_err_excl", 32'(rid ? (D_Ack & D_Err) : (C_Ack & C_Err)), 32'd0);
                    check("rdata", 32'(rid ? D_Rdata : C_Rdata), 32'(e_mon.rdata));
                    check("mem_pulses", 32'(pulse_cnt), e_mon.err ? 32'd0 : 32'd1);
                    if (!e_mon.err) begin
                        check("mem_addr", 32'(pulse_addr), 32'(e_mon.addr));
                        check("mem_dir", 32'(pulse_wr), 32'(e_mon.wr));
                    end
                    if (gap_chk && last_resp_cyc >= 0)
                        check("ack_gap", 32'(cyc - last_resp_cyc), 32'd3);
                    last_resp_cyc = cyc;
                    $display("txn %s wr=%0b addr=%h err=%0b rdata=%h",
                             rid ? "DBG" : "CPU", e_mon.wr, e_mon.addr,
                             rid ? D_Err : C_Err, rid ? D_Rdata : C_Rdata);
                end
                pulse_cnt = 0;
            end
            if (Mem_Rd | Mem_Wr) begin
                check("rd_wr_excl", 32'(Mem_Rd & Mem_Wr), 32'd0);
                pulse_cnt++;
                pulse_addr = Mem_Addr;
                pulse_wr   = Mem_Wr;
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"},   32'(Busy), 32'd0);
        check({tag, "_rd"},     32'(Mem_Rd), 32'd0);
        check({tag, "_wr"},     32'(Mem_Wr), 32'd0);
        check({tag, "_addr"},   32'(Mem_Addr), 32'd0);
        check({tag, "_wdata"},  32'(Mem_Wdata), 32'd0);
        check({tag, "_acks"},   32'({C_Ack, C_Err, D_Ack, D_Err}), 32'd0);
        check({tag, "_crdata"}, 32'(C_Rdata), 32'd0);
        check({tag, "_drdata"}, 32'(D_Rdata), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        reset_checks("reset");
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        Reset = 1'b0;
    endtask

    task automatic do_req(input logic id, input logic wr,
                          input logic [11:0] addr, input logic [15:0] wdata);
        int   lat;
        logic resp;
        logic bad;
        @(negedge Clk);
        bad = (addr > 12'hEFF);
        expect_txn(id, wr, addr, wdata);
        if (id) begin
            D_Wr = wr; D_Addr = addr; D_Wdata = wdata; D_Req = 1'b1;
        end else begin
            C_Wr = wr; C_Addr = addr; C_Wdata = wdata; C_Req = 1'b1;
        end
        lat  = 0;
        resp = 1'b0;
        while (!resp && lat < 20) begin
            @(negedge Clk);
            lat++;
            resp = id ? (D_Ack | D_Err) : (C_Ack | C_Err);
        end
        check("latency", 32'(lat), bad ? 32'd1 : 32'd2);
        if (id) D_Req = 1'b0; else C_Req = 1'b0;
    endtask

    // Both requesters hold a read continuously; grants must alternate from CPU.
    task automatic hold_both(input int n);
        int waited;
        @(negedge Clk);
        for (int i = 0; i < n; i++)
            expect_txn(1'(i % 2), 1'b0, (i % 2 == 1) ? 12'h020 : 12'h010, 16'h0);
        C_Wr = 1'b0; C_Addr = 12'h010;
        D_Wr = 1'b0; D_Addr = 12'h020;
        gap_chk = 1'b1;
        last_resp_cyc = -1;
        C_Req = 1'b1;
        D_Req = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20 * n) begin
            @(posedge Clk);
            #2;
            waited++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        C_Req = 1'b0;
        D_Req = 1'b0;
        gap_chk = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]       = 16'(i * 13 + 7);
            model_mem[i] = 16'(i * 13 + 7);
        end
        mem[12'h010]       = 16'hBEEF;
        model_mem[12'h010] = 16'hBEEF;
        model_rdata[0] = '0;
        model_rdata[1] = '0;

        Reset = 1'b1;
        C_Req = 1'b0; C_Wr = 1'b0; C_Addr = '0; C_Wdata = '0;
        D_Req = 1'b0; D_Wr = 1'b0; D_Addr = '0; D_Wdata = '0;
        repeat (2) @(negedge Clk);
        reset_checks("init");
        Reset = 1'b0;

        do_req(1'b0, 1'b0, 12'h010, 16'h0000);
        do_req(1'b1, 1'b1, 12'h020, 16'h1234);
        do_req(1'b0, 1'b0, 12'h020, 16'h0000);
        do_req(1'b0, 1'b0, 12'hF00, 16'h0000);
        do_req(1'b0, 1'b0, 12'hEFF, 16'h0000);
        do_req(1'b1, 1'b0, 12'hF00, 16'h0000);
        do_req(1'b1, 1'b1, 12'hEFF, 16'hA5A5);
        do_req(1'b1, 1'b0, 12'hEFF, 16'h0000);
        do_req(1'b0, 1'b1, 12'hFFF, 16'hDEAD);

        do_reset();
        hold_both(6);

        // Reset in the middle of an ACCESS cycle abandons the read.
        @(negedge Clk);
        C_Wr = 1'b0; C_Addr = 12'h030; C_Req = 1'b1;
        @(posedge Clk);
        #1;
        check("mid_access_rd", 32'(Mem_Rd), 32'd1);
        check("mid_access_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        reset_checks("mid_reset");
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        @(negedge Clk);
        C_Req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        hold_both(2);

        repeat (4) @(negedge Clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mu0_mem_arbiter.md
MU0_MEM_ARBITER -- requirements
Module: mu0_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_TOP, default 12'hEFF, highest valid RAM address.
REQ-002 SHALL have port Clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports C_Req, C_Wr  input  1 each  CPU request valid; 1=write, 0=read.
REQ-005 SHALL have ports C_Addr  input  12 and C_Wdata  input  16  CPU address and write data.
REQ-006 SHALL have ports C_Ack, C_Err  output  1 each and C_Rdata  output  16  CPU completion pulse, error pulse and read data.
REQ-007 SHALL have ports D_Req, D_Wr, D_Addr, D_Wdata, D_Ack, D_Err, D_Rdata, same widths and directions as the CPU set, for the debug/loader requester.
REQ-008 SHALL have ports Mem_Wr, Mem_Rd  output  1 each, Mem_Addr  output  12 and Mem_Wdata  output  16, all driving the single-port RAM.
REQ-009 SHALL have port Mem_Rdata  input  16  RAM read data, updated by the RAM on negedge Clk.
REQ-010 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-012 IDLE: no Req -> stay IDLE; at least one Req sampled at posedge k -> pick winner, latch its Wr/Addr/Wdata, go ACCESS, or go RESP directly if the latched Addr > MEM_TOP.
REQ-013 Arbitration SHALL be 2-way round-robin: a sole requester wins; on simultaneous requests the requester not served last wins; the Last register updates only on a grant.
REQ-014 ACCESS (cycle k..k+1): Mem_Addr/Mem_Wdata = latched values; Mem_Rd=1 for a read or Mem_Wr=1 for a write, never both; the next state is RESP.
REQ-015 At posedge k+1, a read SHALL capture Mem_Rdata into the winner's Rdata; a write SHALL leave Rdata unchanged.
REQ-016 RESP SHALL pulse the winner's Ack (or Err) high for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be Req sampled at posedge k -> Ack high after posedge k+1; throughput SHALL be at most one access per 3 cycles.
REQ-018 Out-of-range access (Addr > MEM_TOP) SHALL assert Err instead of Ack, issue no Mem_Rd/Mem_Wr, and leave Rdata unchanged; it still counts as a grant for round-robin.
REQ-019 A requester SHALL hold Req/Wr/Addr/Wdata stable until its Ack/Err and drop Req in the cycle after; the arbiter SHALL ignore input changes after latching.
REQ-020 Req deasserted during ACCESS SHALL NOT abort; the access completes and Ack still pulses.
REQ-021 Mem_Rd and Mem_Wr SHALL be 0 in IDLE and RESP; the loser's Ack/Err SHALL stay 0.
REQ-022 Addr = MEM_TOP SHALL be valid; Addr = MEM_TOP+1 SHALL be an error.

Reset
REQ-023 Reset SHALL asynchronously force state IDLE, Last=D (CPU wins the first tie), all Ack/Err/Mem_Rd/Mem_Wr/Busy = 0, Mem_Addr/Mem_Wdata/C_Rdata/D_Rdata = 0.
REQ-024 Reset asserted during ACCESS or RESP SHALL abandon the access with no Ack/Err issued after release.
REQ-025 After Reset deasserts, the first posedge SHALL evaluate requests normally from IDLE.

Structure
REQ-026 Package mu0_mem_arb_pkg SHALL hold the state enum, the requester-id type (CPU/DBG) and the MEM_TOP default constant.
REQ-027 Sub-module mu0_rr_arbiter (2-way round-robin picker owning the Last register) SHALL be instantiated once.

Verification
REQ-028 CPU read: mem[12'h010]=16'hBEEF, C_Req with C_Addr=12'h010 -> Mem_Rd high for one cycle, C_Ack 2 edges later, C_Rdata=16'hBEEF.
REQ-029 DBG write: D_Wr=1, D_Addr=12'h020, D_Wdata=16'h1234 -> Mem_Wr for one cycle, D_Ack; a subsequent CPU read of 12'h020 returns 16'h1234.
REQ-030 Both requesters held continuously from reset -> grants alternate C, D, C, D; one Ack every 3 cycles; never two Acks in the same cycle.
REQ-031 C_Addr=12'hF00 -> C_Err pulse, no Mem_Rd/Mem_Wr, C_Rdata unchanged; C_Addr=12'hEFF -> C_Ack.
REQ-032 Reset asserted mid-ACCESS -> all outputs 0 immediately, no Ack after release, next simultaneous request granted to CPU.
